// File: rtl/kmap_sweep_if.sv
// Handshake and data bundle between the K-map sweep sequencer, its host and the function block.
// The master side is the host/bench; the slave side is the sequencer itself.
interface kmap_sweep_if;
    logic        start;
    logic [15:0] exp_tt;
    logic        f_in;
    logic        d;
    logic        c;
    logic        b;
    logic        a;
    logic        busy;
    logic        done;
    logic [15:0] tt;
    logic        pass;
    logic [4:0]  mism_cnt;
    logic [3:0]  first_err_idx;

    modport master (
        output start, exp_tt, f_in,
        input  d, c, b, a, busy, done, tt, pass, mism_cnt, first_err_idx
    );

    modport slave (
        input  start, exp_tt, f_in,
        output d, c, b, a, busy, done, tt, pass, mism_cnt, first_err_idx
    );
endinterface

// File: rtl/kmap_sweep_ctrl.sv
// Sweeps a 4-input function block through all 16 minterms, samples F after DWELL settle
// cycles per vector, and reports the captured truth table against a latched expected table.
module kmap_sweep_ctrl #(
    parameter int DWELL = 2
) (
    input  logic        clk,
    input  logic        rst,
    kmap_sweep_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] tt_q, tt_d;
    logic        pass_q, pass_d;
    logic [4:0]  mism_q, mism_d;
    logic [3:0]  ferr_q, ferr_d;
    logic        mismatch;
    logic        active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 8'd0;
            exp_q   <= 16'd0;
            tt_q    <= 16'd0;
            pass_q  <= 1'b0;
            mism_q  <= 5'd0;
            ferr_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            pass_q  <= pass_d;
            mism_q  <= mism_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        tt_d     = tt_q;
        pass_d   = pass_q;
        mism_d   = mism_q;
        ferr_d   = ferr_q;
        mismatch = (bus.f_in != exp_q[idx_q]);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    exp_d   = bus.exp_tt;
                    tt_d    = 16'd0;
                    pass_d  = 1'b0;
                    mism_d  = 5'd0;
                    ferr_d  = 4'd0;
                    idx_d   = 4'd0;
                    cnt_d   = 8'd0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SAMPLE: begin
                tt_d[idx_q] = bus.f_in;
                if (mismatch) begin
                    mism_d = mism_q + 5'd1;
                    if (mism_q == 5'd0) begin
                        ferr_d = idx_q;
                    end
                end
                // pass is resolved here so it is already valid in the done cycle
                if (idx_q == 4'd15) begin
                    pass_d  = (mism_d == 5'd0);
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = SETTLE;
                end
            end
            FINISH: begin
                idx_d   = 4'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign active            = (state_q == SETTLE) || (state_q == SAMPLE);
    assign {bus.d, bus.c, bus.b, bus.a} = active ? idx_q : 4'd0;
    assign bus.busy          = active;
    assign bus.done          = (state_q == FINISH);
    assign bus.tt            = tt_q;
    assign bus.pass          = pass_q;
    assign bus.mism_cnt      = mism_q;
    assign bus.first_err_idx = ferr_q;
endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Bench for kmap_sweep_ctrl at DWELL = 2, 1 and 255: directed and random sweeps checked
// against a truth-table model of the function block and a cycle-timeline model of the sweep.
module tb_kmap_sweep_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_r;
    logic [15:0] exp_r;
    logic [15:0] f_tab;
    int          sel;
    int          total  = 0;
    int          passed = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    kmap_sweep_if u_if2 ();
    kmap_sweep_if u_if1 ();
    kmap_sweep_if u_if255 ();

    kmap_sweep_ctrl #(.DWELL(2))   dut2   (.clk(clk), .rst(rst), .bus(u_if2));
    kmap_sweep_ctrl #(.DWELL(1))   dut1   (.clk(clk), .rst(rst), .bus(u_if1));
    kmap_sweep_ctrl #(.DWELL(255)) dut255 (.clk(clk), .rst(rst), .bus(u_if255));

    assign u_if2.start    = start_r && (sel == 2);
    assign u_if1.start    = start_r && (sel == 1);
    assign u_if255.start  = start_r && (sel == 255);
    assign u_if2.exp_tt   = exp_r;
    assign u_if1.exp_tt   = exp_r;
    assign u_if255.exp_tt = exp_r;
    assign u_if2.f_in     = f_tab[{u_if2.d, u_if2.c, u_if2.b, u_if2.a}];
    assign u_if1.f_in     = f_tab[{u_if1.d, u_if1.c, u_if1.b, u_if1.a}];
    assign u_if255.f_in   = f_tab[{u_if255.d, u_if255.c, u_if255.b, u_if255.a}];

    logic [3:0]  o_vec;
    logic        o_busy, o_done, o_pass;
    logic [15:0] o_tt;
    logic [4:0]  o_mism;
    logic [3:0]  o_fe;

    always_comb begin
        o_vec  = {u_if2.d, u_if2.c, u_if2.b, u_if2.a};
        o_busy = u_if2.busy;
        o_done = u_if2.done;
        o_pass = u_if2.pass;
        o_tt   = u_if2.tt;
        o_mism = u_if2.mism_cnt;
        o_fe   = u_if2.first_err_idx;
        if (sel == 1) begin
            o_vec  = {u_if1.d, u_if1.c, u_if1.b, u_if1.a};
            o_busy = u_if1.busy;
            o_done = u_if1.done;
            o_pass = u_if1.pass;
            o_tt   = u_if1.tt;
            o_mism = u_if1.mism_cnt;
            o_fe   = u_if1.first_err_idx;
        end else if (sel == 255) begin
            o_vec  = {u_if255.d, u_if255.c, u_if255.b, u_if255.a};
            o_busy = u_if255.busy;
            o_done = u_if255.done;
            o_pass = u_if255.pass;
            o_tt   = u_if255.tt;
            o_mism = u_if255.mism_cnt;
            o_fe   = u_if255.first_err_idx;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] popc(input logic [15:0] v);
        logic [4:0] n = 5'd0;
        for (int k = 0; k < 16; k++) n += {4'd0, v[k]};
        return n;
    endfunction

    function automatic logic [3:0] lowest(input logic [15:0] v);
        logic [3:0] r = 4'd0;
        for (int k = 15; k >= 0; k--) if (v[k]) r = 4'(k);
        return r;
    endfunction

    task automatic chk_cleared(input string tag);
        chk({tag, "_vec"},  {28'd0, o_vec}, 0);
        chk({tag, "_busy"}, {31'd0, o_busy}, 0);
        chk({tag, "_done"}, {31'd0, o_done}, 0);
        chk({tag, "_tt"},   {16'd0, o_tt}, 0);
        chk({tag, "_pass"}, {31'd0, o_pass}, 0);
        chk({tag, "_mism"}, {27'd0, o_mism}, 0);
        chk({tag, "_fe"},   {28'd0, o_fe}, 0);
    endtask

    // One full sweep; the expected timeline comes from vector k owning cycles
    // 1+k*(dw+1) .. (k+1)*(dw+1) and done landing at 16*(dw+1)+1.
    task automatic sweep(input int dw, input logic [15:0] ftab, input logic [15:0] expv,
                         input bit hold, input bit chg_exp);
        int          t_done;
        int          seq_bad   = 0;
        int          first_bad = 0;
        int          stray     = 0;
        logic [15:0] tt_exp;
        logic [15:0] diff;
        logic [3:0]  vec_exp;
        logic        busy_exp;

        t_done = 16 * (dw + 1) + 1;
        for (int k = 0; k < 16; k++) tt_exp[k] = ftab[k];
        diff  = tt_exp ^ expv;
        sel   = dw;
        f_tab = ftab;
        exp_r = expv;
        start_r = 1'b1;
        for (int t = 1; t <= t_done + 1; t++) begin
            tick();
            if (!hold) start_r = 1'b0;
            busy_exp = (t < t_done);
            vec_exp  = busy_exp ? 4'((t - 1) / (dw + 1)) : 4'd0;
            if (o_vec !== vec_exp || o_busy !== busy_exp) begin
                if (seq_bad == 0) first_bad = t;
                seq_bad++;
            end
            if (o_done === 1'b1 && t != t_done) stray++;
            if (chg_exp && o_vec == 4'd5) exp_r = 16'hFFFF;
            if (t == t_done) begin
                chk($sformatf("done_at_%0d", t_done), {31'd0, o_done}, 1);
                chk("tt",        {16'd0, o_tt}, {16'd0, tt_exp});
                chk("pass",      {31'd0, o_pass}, {31'd0, diff == 16'd0});
                chk("mism_cnt",  {27'd0, o_mism}, {27'd0, popc(diff)});
                chk("first_err", {28'd0, o_fe}, {28'd0, lowest(diff)});
            end
        end
        chk($sformatf("vec_seq_dw%0d_first_bad_cycle_%0d", dw, first_bad), seq_bad, 0);
        chk("stray_done", stray, 0);
        chk("hold_tt",   {16'd0, o_tt}, {16'd0, tt_exp});
        chk("hold_mism", {27'd0, o_mism}, {27'd0, popc(diff)});
        if (hold) begin
            tick();
            chk("restart_after_idle", {31'd0, o_busy}, 1);
        end
    endtask

    initial begin
        int          guard;
        int          dones;
        logic [15:0] ft;
        logic [15:0] ev;

        rst     = 1'b1;
        start_r = 1'b0;
        exp_r   = 16'd0;
        f_tab   = 16'd0;
        sel     = 2;
        tick();
        tick();
        rst = 1'b0;
        chk_cleared("reset");

        sweep(2, 16'hA5F0, 16'hA5F0, 1'b0, 1'b0);
        sweep(2, 16'hA5F0 ^ 16'h1008, 16'hA5F0, 1'b0, 1'b0);
        chk("inv_3_12_tt", {16'd0, o_tt}, 32'h0000B5F8);

        // start held through the sweep, exp_tt changed mid-sweep, then abort the restart at idx 7
        sweep(2, 16'hA5F0, 16'hA5F0, 1'b1, 1'b1);
        start_r = 1'b0;
        exp_r   = 16'hA5F0;
        guard   = 0;
        while (!(o_busy === 1'b1 && o_vec === 4'd7) && guard < 200) begin
            tick();
            guard++;
        end
        chk("reach_idx7", {31'd0, guard < 200}, 1);
        rst = 1'b1;
        tick();
        chk_cleared("abort");
        tick();
        rst   = 1'b0;
        dones = 0;
        for (int t = 0; t < 120; t++) begin
            tick();
            if (o_done === 1'b1) dones++;
        end
        chk("no_done_after_abort", dones, 0);

        for (int r = 0; r < 3; r++) begin
            ft = 16'($urandom);
            ev = (r == 0) ? ft : ft ^ 16'($urandom);
            sweep(2, ft, ev, 1'b0, 1'b0);
        end

        sweep(1, 16'hA5F0, 16'hA5F0, 1'b0, 1'b0);
        ft = 16'($urandom);
        sweep(1, ft, ~ft, 1'b0, 1'b0);
        ft = 16'($urandom);
        sweep(1, ft, ft ^ (16'h8000 >> $urandom_range(0, 15)), 1'b0, 1'b0);

        ft = 16'($urandom);
        sweep(255, ft, ft ^ 16'($urandom), 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
